// File: rtl/pclk_mon_pkg.sv
// Shared types and DataBusWidth -> PCLK divide decode for the PCLK ratio monitor.
package pclk_mon_pkg;

    typedef enum logic [1:0] {IDLE, ARM, ACQUIRE, LOCKED} mon_state_e;

    localparam logic [7:0] RATIO_8  = 8'd10;
    localparam logic [7:0] RATIO_16 = 8'd20;
    localparam logic [7:0] RATIO_32 = 8'd40;

    function automatic logic [7:0] exp_ratio(input logic [5:0] width);
        case (width)
            6'd8:    return RATIO_8;
            6'd16:   return RATIO_16;
            6'd32:   return RATIO_32;
            default: return RATIO_8;
        endcase
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detect for clocks sampled as data.
module edge_sync (
    input  logic Ref_Clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [1:0] sync_q;
    logic       edge_q;

    always_ff @(posedge Ref_Clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            edge_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~edge_q;

endmodule

// File: rtl/pclk_ratio_monitor.sv
// Measures PCLK period in bit-rate cycles and tracks lock against the
// divide ratio implied by DataBusWidth.
module pclk_ratio_monitor
    import pclk_mon_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic       Ref_Clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [5:0] DataBusWidth,
    input  logic       mon_clk,
    output logic       locked,
    output logic       ratio_err,
    output logic [7:0] measured_period,
    output logic [7:0] err_count
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [3:0] LOCK_C    = 4'(LOCK_CNT);
    localparam logic [8:0] TOL_C     = 9'(TOL);

    mon_state_e state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] good_cnt, good_n;
    logic [5:0] dbw_q;
    logic       err_n, per_load, rise;
    logic [8:0] exp9, per9;
    logic       in_tol, width_chg, timeout;

    edge_sync u_edge_sync (
        .Ref_Clk (Ref_Clk),
        .rst     (rst),
        .din     (mon_clk),
        .rise    (rise)
    );

    assign exp9      = {1'b0, exp_ratio(DataBusWidth)};
    assign per9      = {1'b0, cnt};
    // Lower bound written as period+TOL >= exp so small ratios cannot underflow.
    assign in_tol    = (per9 + TOL_C >= exp9) && (per9 <= exp9 + TOL_C);
    assign width_chg = (DataBusWidth != dbw_q);
    assign timeout   = (cnt == TIMEOUT_C);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        good_n   = good_cnt;
        err_n    = 1'b0;
        per_load = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            good_n  = '0;
        end else if (state == IDLE) begin
            state_n = ARM;
        end else if (width_chg) begin
            state_n = ARM;
            cnt_n   = '0;
            good_n  = '0;
        end else if (state == ARM) begin
            if (rise) begin
                state_n = ACQUIRE;
                cnt_n   = 8'd1;
            end
        end else if (timeout) begin
            err_n   = 1'b1;
            state_n = ARM;
            cnt_n   = '0;
            good_n  = '0;
        end else if (rise) begin
            cnt_n    = 8'd1;
            per_load = 1'b1;
            if (!in_tol) begin
                err_n   = 1'b1;
                good_n  = '0;
                state_n = ACQUIRE;
            end else if (state == ACQUIRE) begin
                good_n = good_cnt + 4'd1;
                if (good_n == LOCK_C) state_n = LOCKED;
            end
        end else begin
            cnt_n = cnt + 8'd1;
        end
    end

    always_ff @(posedge Ref_Clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            good_cnt        <= '0;
            dbw_q           <= '0;
            ratio_err       <= 1'b0;
            measured_period <= '0;
            err_count       <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            good_cnt  <= good_n;
            dbw_q     <= DataBusWidth;
            ratio_err <= err_n;
            if (per_load) measured_period <= cnt;
            if (err_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_pclk_ratio_monitor.sv
// Scoreboard bench: stimulus queues expected lock/drop/error events, a monitor
// pops and compares them as the DUT produces them.
module tb_pclk_ratio_monitor;
    import pclk_mon_pkg::*;

    typedef enum logic [1:0] {EV_LOCK, EV_DROP, EV_ERR} ev_e;
    typedef struct packed {
        ev_e        kind;
        logic [7:0] period;
        logic [7:0] errs;
    } ev_t;

    logic       Ref_Clk = 1'b0;
    logic       rst, enable, mon_clk;
    logic [5:0] DataBusWidth;
    logic       locked, ratio_err;
    logic [7:0] measured_period, err_count;
    logic       prev_locked = 1'b0;

    int  compared   = 0;
    int  mismatched = 0;
    ev_t exp_q[$];

    always #5 Ref_Clk = ~Ref_Clk;

    pclk_ratio_monitor dut (
        .Ref_Clk         (Ref_Clk),
        .rst             (rst),
        .enable          (enable),
        .DataBusWidth    (DataBusWidth),
        .mon_clk         (mon_clk),
        .locked          (locked),
        .ratio_err       (ratio_err),
        .measured_period (measured_period),
        .err_count       (err_count)
    );

    function automatic void check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    function automatic void push(input ev_e k, input int p, input int e);
        ev_t ev;
        ev.kind   = k;
        ev.period = 8'(p);
        ev.errs   = 8'(e);
        exp_q.push_back(ev);
    endfunction

    // Monitor: one observed event per cycle at most; an error pulse that also
    // drops lock is reported as a single error event.
    always @(negedge Ref_Clk) begin
        ev_t ob, ex;
        bit  hit;
        hit = 1'b1;
        ob  = '0;
        if (ratio_err)                   ob = '{EV_ERR,  measured_period, err_count};
        else if (locked && !prev_locked) ob = '{EV_LOCK, measured_period, err_count};
        else if (!locked && prev_locked) ob = '{EV_DROP, measured_period, err_count};
        else hit = 1'b0;
        prev_locked <= locked;
        if (hit) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: got kind %0d at %0t, expected none", int'(ob.kind), $time);
            end else begin
                ex = exp_q.pop_front();
                check("ev_kind",   int'(ob.kind),   int'(ex.kind));
                check("ev_period", int'(ob.period), int'(ex.period));
                check("ev_errs",   int'(ob.errs),   int'(ex.errs));
                if (ob.kind == EV_ERR) check("err_unlocked", int'(locked), 0);
            end
        end
    end

    task automatic run_clk(input int div, input int n);
        repeat (n) begin
            mon_clk = 1'b1;
            repeat (div / 2) @(negedge Ref_Clk);
            mon_clk = 1'b0;
            repeat (div - div / 2) @(negedge Ref_Clk);
        end
    endtask

    initial begin
        repeat (30000) @(posedge Ref_Clk);
        $display("FAIL watchdog: got timeout expected completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; mon_clk = 1'b0; DataBusWidth = 6'd8;
        repeat (3) @(negedge Ref_Clk);
        check("rst_locked",    int'(locked), 0);
        check("rst_ratio_err", int'(ratio_err), 0);
        check("rst_period",    int'(measured_period), 0);
        check("rst_err_count", int'(err_count), 0);

        // Width 8, divide 10: lock after arming edge + 4 good periods.
        rst = 1'b0; enable = 1'b1;
        push(EV_LOCK, 10, 0);
        run_clk(10, 8);
        check("w8_period", int'(measured_period), 10);
        check("w8_errs",   int'(err_count), 0);

        enable = 1'b0;
        push(EV_DROP, 10, 0);
        repeat (3) @(negedge Ref_Clk);
        check("dis_state", int'(dut.state), int'(IDLE));
        check("dis_errs",  int'(err_count), 0);

        // Width 32, divide 40, one short period, relock.
        DataBusWidth = 6'd32; enable = 1'b1;
        push(EV_LOCK, 40, 0);
        run_clk(40, 6);
        push(EV_ERR, 39, 1);
        push(EV_LOCK, 40, 1);
        run_clk(39, 1);
        run_clk(40, 6);
        check("w32_locked", int'(locked), 1);

        // Stopped clock while locked: single timeout error, back to ARM.
        push(EV_ERR, 40, 2);
        repeat (300) @(negedge Ref_Clk);
        check("to_state",  int'(dut.state), int'(ARM));
        check("to_locked", int'(locked), 0);
        push(EV_LOCK, 40, 2);
        run_clk(40, 6);

        // Width changes drop lock silently, then relock at the new ratio.
        DataBusWidth = 6'd8;
        push(EV_DROP, 40, 2);
        push(EV_LOCK, 10, 2);
        run_clk(10, 6);
        DataBusWidth = 6'd16;
        push(EV_DROP, 10, 2);
        push(EV_LOCK, 20, 2);
        run_clk(20, 6);
        check("w16_period", int'(measured_period), 20);

        // Unlisted width decodes to ratio 10.
        DataBusWidth = 6'd5;
        push(EV_DROP, 20, 2);
        push(EV_LOCK, 10, 2);
        run_clk(10, 6);

        // Width 16 with divide 10: every period errors; count saturates.
        DataBusWidth = 6'd16;
        push(EV_DROP, 10, 2);
        for (int i = 1; i <= 259; i++) push(EV_ERR, 10, (2 + i > 255) ? 255 : 2 + i);
        run_clk(10, 260);
        check("sat_errs", int'(err_count), 255);

        DataBusWidth = 6'd8;
        push(EV_LOCK, 10, 255);
        run_clk(10, 6);

        enable = 1'b0;
        push(EV_DROP, 10, 255);
        repeat (3) @(negedge Ref_Clk);
        check("dis2_state",  int'(dut.state), int'(IDLE));
        check("dis2_errs",   int'(err_count), 255);
        check("dis2_period", int'(measured_period), 10);

        // Async reset in the middle of acquisition.
        enable = 1'b1;
        run_clk(10, 3);
        check("acq_state", int'(dut.state), int'(ACQUIRE));
        #2 rst = 1'b1;
        #1;
        check("arst_state",  int'(dut.state), int'(IDLE));
        check("arst_period", int'(measured_period), 0);
        check("arst_errs",   int'(err_count), 0);
        check("arst_err",    int'(ratio_err), 0);
        @(negedge Ref_Clk);
        rst = 1'b0; enable = 1'b0;
        repeat (2) @(negedge Ref_Clk);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
